// File: rtl/rx_corr_pkg.sv
// Shared types and constants for the rx_corr_mac matched-filter correlator.
package rx_corr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int DEF_CORR_LENGTH = 510;
  // One sign bit plus growth of a full-scale 16-bit sample summed CORR_LENGTH times.
  localparam int DEF_ACC_W = 16 + clog2(DEF_CORR_LENGTH) + 1;

endpackage

// File: rtl/rx_corr_mac_if.sv
// Sample-burst / result bus between the sample BRAM, the correlator and the detector.
interface rx_corr_mac_if
  import rx_corr_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
);
  logic                    erx_en;
  logic                    inew_sample_trig;
  logic                    idata_valid;
  logic signed [15:0]      idata_in;
  logic                    ipeak_clear;
  logic signed [ACC_W-1:0] ocorr_value;
  logic                    ocorr_valid;
  logic                    obusy;
  logic                    ooverrun;
  logic signed [ACC_W-1:0] opeak_value;
  logic [15:0]             opeak_index;

  modport master (
    output erx_en, inew_sample_trig, idata_valid, idata_in, ipeak_clear,
    input  ocorr_value, ocorr_valid, obusy, ooverrun, opeak_value, opeak_index
  );

  modport slave (
    input  erx_en, inew_sample_trig, idata_valid, idata_in, ipeak_clear,
    output ocorr_value, ocorr_valid, obusy, ooverrun, opeak_value, opeak_index
  );
endinterface

// File: rtl/rx_corr_code_rom.sv
// Reference chip ROM: one bit per chip (1 = +1, 0 = -1), registered read keyed on the chip index.
module rx_corr_code_rom #(
  parameter int                     CORR_LENGTH = 510,
  parameter int                     ADDR_W      = 9,
  parameter logic [CORR_LENGTH-1:0] CODE_INIT   = '1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic              chip
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chip <= 1'b0;
    end else if (en) begin
      chip <= CODE_INIT[addr];
    end
  end

endmodule

// File: rtl/rx_corr_mac.sv
// Matched-filter correlator: one signed +/-1-weighted sum of CORR_LENGTH samples per trigger.
// Optional peak-magnitude tracker compiled in with `define RX_CORR_PEAK_TRACK_EN.
module rx_corr_mac
  import rx_corr_pkg::*;
#(
  parameter int                     CORR_LENGTH = DEF_CORR_LENGTH,
  parameter int                     ACC_W       = DEF_ACC_W,
  parameter logic [CORR_LENGTH-1:0] CODE_INIT   = '1
) (
  input logic          crx_clk,
  input logic          rrx_rst,
  rx_corr_mac_if.slave bus
);

  localparam int IDX_W = clog2(CORR_LENGTH);

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic                    trig, accept, last, overrun;
  logic                    chip;
  logic                    s1_v, s1_first, s1_last;
  logic signed [15:0]      s1_sample;
  logic signed [ACC_W-1:0] sample_ext;
  logic                    s2_v, s2_first, s2_last;
  logic signed [ACC_W-1:0] prod, acc, value_r;
  logic                    s3_last, valid_r;

  assign trig   = bus.erx_en && bus.inew_sample_trig;
  assign accept = bus.erx_en && (state == ACCUM) && bus.idata_valid && !bus.inew_sample_trig;
  assign last   = accept && (idx == IDX_W'(CORR_LENGTH - 1));

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (bus.erx_en) begin
      if (trig) begin
        state_nxt = ACCUM;
        idx_nxt   = '0;
      end else begin
        case (state)
          ACCUM: begin
            if (accept) begin
              idx_nxt = idx + 1'b1;
              if (last) state_nxt = DONE;
            end
          end
          DONE: begin
            if (valid_r) state_nxt = IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      state   <= IDLE;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (trig && (state != IDLE)) overrun <= 1'b1;
    end
  end

  rx_corr_code_rom #(
    .CORR_LENGTH(CORR_LENGTH),
    .ADDR_W     (IDX_W),
    .CODE_INIT  (CODE_INIT)
  ) u_rom (
    .clk (crx_clk),
    .rst (rrx_rst),
    .en  (accept),
    .addr(idx),
    .chip(chip)
  );

  assign sample_ext = {{(ACC_W - 16){s1_sample[15]}}, s1_sample};

  // Samples carry first/last tags so a restart never needs to clear the accumulator
  // while the previous burst's tail is still draining into the result register.
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      s1_v      <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sample <= '0;
      s2_v      <= 1'b0;
      s2_first  <= 1'b0;
      s2_last   <= 1'b0;
      prod      <= '0;
      acc       <= '0;
      s3_last   <= 1'b0;
      valid_r   <= 1'b0;
      value_r   <= '0;
    end else if (bus.erx_en) begin
      s1_v     <= accept;
      s1_first <= (idx == '0);
      s1_last  <= last;
      if (accept) s1_sample <= bus.idata_in;
      s2_v     <= s1_v;
      s2_first <= s1_first;
      s2_last  <= s1_v && s1_last;
      prod     <= chip ? sample_ext : -sample_ext;
      if (s2_v) acc <= s2_first ? prod : acc + prod;
      s3_last  <= s2_v && s2_last;
      valid_r  <= s3_last;
      if (s3_last) value_r <= acc;
    end
  end

  assign bus.ocorr_value = value_r;
  assign bus.ocorr_valid = valid_r && bus.erx_en;
  assign bus.obusy       = (state != IDLE);
  assign bus.ooverrun    = overrun;

`ifdef RX_CORR_PEAK_TRACK_EN
  logic signed [ACC_W-1:0] peak_value;
  logic [15:0]             peak_index, result_cnt;
  logic [ACC_W:0]          mag_new, mag_peak;

  // One extra bit so the magnitude of the most negative value is representable.
  assign mag_new  = value_r[ACC_W-1]    ? -{1'b1, value_r}    : {1'b0, value_r};
  assign mag_peak = peak_value[ACC_W-1] ? -{1'b1, peak_value} : {1'b0, peak_value};

  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      peak_value <= '0;
      peak_index <= '0;
      result_cnt <= '0;
    end else if (bus.erx_en) begin
      if (bus.ipeak_clear) begin
        peak_value <= '0;
        peak_index <= '0;
        result_cnt <= '0;
      end else if (valid_r) begin
        if (mag_new > mag_peak) begin
          peak_value <= value_r;
          peak_index <= result_cnt;
        end
        if (result_cnt != 16'hFFFF) result_cnt <= result_cnt + 16'd1;
      end
    end
  end

  assign bus.opeak_value = peak_value;
  assign bus.opeak_index = peak_index;
`else
  logic unused_peak_clear;
  assign unused_peak_clear = bus.ipeak_clear;
  assign bus.opeak_value   = '0;
  assign bus.opeak_index   = '0;
`endif

endmodule
